// File: rtl/inst_sram_slave.sv
// inst_sram_slave: responder for the instruction-SRAM request port.
// Fully pipelined synchronous SRAM of 64-bit words with byte-lane masked writes.
// One request is accepted per cycle. Each request produces exactly one response
// LATENCY cycles later.
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active-high; clears the response pipeline only
//   sram_en      request valid
//   sram_we      byte write enables; nonzero selects a write
//   sram_addr    byte address
//   sram_wdata   write data, byte i on bits [8i+7:8i]
//   sram_rvalid  one-cycle response pulse
//   sram_rdata   word read; 0 for writes, errors and idle cycles
//   sram_inst    32-bit half of the word selected by addr[2]; 0 like rdata
//   sram_err     request was rejected (out of range or misaligned read)
module inst_sram_slave #(
    parameter int unsigned DEPTH   = 4096,
    parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_en,
    input  logic [7:0]  sram_we,
    input  logic [63:0] sram_addr,
    input  logic [63:0] sram_wdata,
    output logic        sram_rvalid,
    output logic [63:0] sram_rdata,
    output logic [31:0] sram_inst,
    output logic        sram_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [63:0] mem [DEPTH];

    logic [63:0] off;
    logic [AW-1:0] mem_idx;
    logic        in_range;
    logic        is_write;
    logic        req_err;
    logic [63:0] req_rdata;

    // Response pipeline; stage LATENCY-1 drives the outputs.
    logic [LATENCY-1:0]       valid_q;
    logic [LATENCY-1:0]       addr2_q;
    logic [LATENCY-1:0]       err_q;
    logic [LATENCY-1:0][63:0] rdata_q;

    always_comb begin
        off      = sram_addr - BASE;
        mem_idx  = off[AW+2:3];
        // The explicit addr >= BASE term stops addresses below BASE from
        // wrapping around the subtract into a small index.
        in_range = (sram_addr >= BASE) && ({3'b000, off[63:3]} < 64'(DEPTH));
        is_write = |sram_we;
        req_err  = is_write ? !in_range : (!in_range || (sram_addr[1:0] != 2'b00));
        req_rdata = (is_write || req_err) ? 64'h0 : mem[mem_idx];
    end

    // Byte offset within the word does not affect indexing.
    logic unused_off;
    assign unused_off = ^off[2:0];

    // Memory is never cleared by reset; requests presented while rst is high
    // are dropped so memory and the discarded responses stay consistent.
    always_ff @(posedge clk) begin
        if (!rst && sram_en && is_write && in_range) begin
            for (int b = 0; b < 8; b++) begin
                if (sram_we[b]) begin
                    mem[mem_idx][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            addr2_q <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            valid_q[0] <= sram_en;
            rdata_q[0] <= sram_en ? req_rdata : 64'h0;
            addr2_q[0] <= sram_en & ~is_write & sram_addr[2];
            err_q[0]   <= sram_en & req_err;
            for (int i = 1; i < int'(LATENCY); i++) begin
                valid_q[i] <= valid_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
                addr2_q[i] <= addr2_q[i-1];
                err_q[i]   <= err_q[i-1];
            end
        end
    end

    always_comb begin
        sram_rvalid = valid_q[LATENCY-1];
        sram_rdata  = 64'h0;
        sram_inst   = 32'h0;
        sram_err    = 1'b0;
        if (valid_q[LATENCY-1]) begin
            sram_rdata = rdata_q[LATENCY-1];
            sram_inst  = addr2_q[LATENCY-1] ? rdata_q[LATENCY-1][63:32]
                                            : rdata_q[LATENCY-1][31:0];
            sram_err   = err_q[LATENCY-1];
        end
    end

endmodule
